// File: rtl/avalon_cmd_pkg.sv
// Shared definitions for the Avalon command master: FSM state encoding,
// the idle levels of the Avalon control strobes and the latency counter width.
package avalon_cmd_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } cmdStateT;

  // Bus levels whenever no transfer is being driven
  localparam logic BUS_IDLE_CS      = 1'b0;
  localparam logic BUS_IDLE_WRITE_N = 1'b1;
  localparam logic BUS_IDLE_READ_N  = 1'b1;

  // Wide enough for the largest supported read latency (7)
  localparam int LAT_W = 3;

endpackage

// File: rtl/avalon_cmd_fifo.sv
// Small synchronous command FIFO. The head entry is presented combinationally
// so the sequencer can consume it in the same cycle it pops.
module avalon_cmd_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iPushData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oPopData,
  output logic             oFull,
  output logic             oEmpty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty
  logic [PTR_W:0]   wrPtrReg;
  logic [PTR_W:0]   rdPtrReg;
  logic             doPush;
  logic             doPop;

  assign doPush   = iPush & ~oFull;
  assign doPop    = iPop & ~oEmpty;
  assign oEmpty   = (wrPtrReg == rdPtrReg);
  assign oFull    = (wrPtrReg[PTR_W] != rdPtrReg[PTR_W]) &&
                    (wrPtrReg[PTR_W-1:0] == rdPtrReg[PTR_W-1:0]);
  assign oPopData = mem[rdPtrReg[PTR_W-1:0]];

  // Storage array, no reset needed: contents are qualified by the pointers
  always_ff @(posedge iClk) begin
    if (doPush) mem[wrPtrReg[PTR_W-1:0]] <= iPushData;
  end

  // Pointer update; reset empties the FIFO immediately
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
      if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
    end
  end

endmodule

// File: rtl/avalon_cmd_master.sv
// Avalon-MM master front end: queues read/write commands, issues one
// single-beat transfer at a time in order, and returns read data on a
// valid/ready response stream. All bus outputs come straight from flops.
module avalon_cmd_master
  import avalon_cmd_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 16
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iCmdValid,
  output logic              oCmdReady,
  input  logic              iCmdWrite,
  input  logic [ADDR_W-1:0] iCmdAddr,
  input  logic [DATA_W-1:0] iCmdData,
  output logic              oRspValid,
  input  logic              iRspReady,
  output logic [DATA_W-1:0] oRspData,
  output logic [ADDR_W-1:0] oRspAddr,
  output logic              oChipselect,
  output logic              oWrite_n,
  output logic              oRead_n,
  output logic [ADDR_W-1:0] oAddress,
  output logic [DATA_W-1:0] oData,
  input  logic [DATA_W-1:0] iData,
  output logic              oBusy,
  output logic [CNT_W-1:0]  oWrCount,
  output logic [CNT_W-1:0]  oRdCount
);

  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  cmdStateT           stateReg;
  logic [ADDR_W-1:0]  cmdAddrReg;
  logic [DATA_W-1:0]  cmdDataReg;
  logic [LAT_W-1:0]   latCntReg;
  logic               csReg;
  logic               writeNReg;
  logic               readNReg;
  logic               rspValidReg;
  logic [DATA_W-1:0]  rspDataReg;
  logic [ADDR_W-1:0]  rspAddrReg;
  logic [CNT_W-1:0]   wrCountReg;
  logic [CNT_W-1:0]   rdCountReg;

  logic               fifoFull;
  logic               fifoEmpty;
  logic [ENTRY_W-1:0] fifoHead;
  logic               headWrite;
  logic [ADDR_W-1:0]  headAddr;
  logic [DATA_W-1:0]  headData;

  avalon_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .iClk      (iClk),
    .iReset    (iReset),
    .iPush     (iCmdValid),
    .iPushData ({iCmdWrite, iCmdAddr, iCmdData}),
    .iPop      (stateReg == IDLE),
    .oPopData  (fifoHead),
    .oFull     (fifoFull),
    .oEmpty    (fifoEmpty)
  );

  assign headWrite = fifoHead[ENTRY_W-1];
  assign headAddr  = fifoHead[ENTRY_W-2 -: ADDR_W];
  assign headData  = fifoHead[DATA_W-1:0];

  assign oCmdReady   = ~fifoFull;
  assign oBusy       = (stateReg != IDLE) || !fifoEmpty;
  assign oChipselect = csReg;
  assign oWrite_n    = writeNReg;
  assign oRead_n     = readNReg;
  assign oAddress    = cmdAddrReg;
  assign oData       = cmdDataReg;
  assign oRspValid   = rspValidReg;
  assign oRspData    = rspDataReg;
  assign oRspAddr    = rspAddrReg;
  assign oWrCount    = wrCountReg;
  assign oRdCount    = rdCountReg;

  // Transaction sequencer; strobes are set on entry to WRITE/READ so they
  // are high for exactly the cycle spent in that state.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      stateReg    <= IDLE;
      cmdAddrReg  <= '0;
      cmdDataReg  <= '0;
      latCntReg   <= '0;
      csReg       <= BUS_IDLE_CS;
      writeNReg   <= BUS_IDLE_WRITE_N;
      readNReg    <= BUS_IDLE_READ_N;
      rspValidReg <= 1'b0;
      rspDataReg  <= '0;
      rspAddrReg  <= '0;
      wrCountReg  <= '0;
      rdCountReg  <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (!fifoEmpty) begin
            cmdAddrReg <= headAddr;
            csReg      <= 1'b1;
            if (headWrite) begin
              // oData only follows writes; reads leave the last write data
              cmdDataReg <= headData;
              writeNReg  <= 1'b0;
              stateReg   <= WRITE;
            end else begin
              readNReg   <= 1'b0;
              stateReg   <= READ;
            end
          end
        end
        WRITE: begin
          csReg     <= BUS_IDLE_CS;
          writeNReg <= BUS_IDLE_WRITE_N;
          if (wrCountReg != {CNT_W{1'b1}}) wrCountReg <= wrCountReg + 1'b1;
          stateReg  <= IDLE;
        end
        READ: begin
          csReg     <= BUS_IDLE_CS;
          readNReg  <= BUS_IDLE_READ_N;
          latCntReg <= LAT_W'(READ_LATENCY);
          stateReg  <= WAIT;
        end
        WAIT: begin
          // Count 1 marks the cycle in which the slave data is valid
          if (latCntReg == LAT_W'(1)) begin
            rspDataReg  <= iData;
            rspAddrReg  <= cmdAddrReg;
            rspValidReg <= 1'b1;
            stateReg    <= RESP;
          end else begin
            latCntReg <= latCntReg - 1'b1;
          end
        end
        RESP: begin
          if (iRspReady) begin
            rspValidReg <= 1'b0;
            if (rdCountReg != {CNT_W{1'b1}}) rdCountReg <= rdCountReg + 1'b1;
            stateReg    <= IDLE;
          end
        end
        default: begin
          csReg     <= BUS_IDLE_CS;
          writeNReg <= BUS_IDLE_WRITE_N;
          readNReg  <= BUS_IDLE_READ_N;
          stateReg  <= IDLE;
        end
      endcase
    end
  end

endmodule
